// File: rtl/face_detect_udiv_23ns_8ns_16_seq.sv
// face_detect_udiv_23ns_8ns_16_seq
//   Iterative radix-2 restoring unsigned divider for the window-normalisation
//   path. It divides a DIVIDEND_WIDTH product by a DIVISOR_WIDTH scale factor
//   and returns a saturated QUOTIENT_WIDTH quotient plus the true remainder.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   ce           clock enable; 0 freezes every register (done included)
//   start        request, accepted when ce=1 and ready=1
//   dividend     unsigned dividend, sampled at accept
//   divisor      unsigned divisor, sampled at accept
//   ready        can accept a new start (IDLE or DONE)
//   done         one enabled-cycle pulse, results valid
//   quotient     saturated quotient (all ones on overflow or divide by zero)
//   remainder    dividend mod divisor (0 on divide by zero)
//   overflow     true quotient does not fit in QUOTIENT_WIDTH bits
//   div_by_zero  divisor was 0
//
// Timing: accept on enabled edge E0, DIVIDEND_WIDTH iteration edges, then one
// edge that saturates and registers the results; done is high in the cycle
// after E0+DIVIDEND_WIDTH+1. Results hold until the next operation finishes.

module face_detect_udiv_23ns_8ns_16_seq #(
    parameter int DIVIDEND_WIDTH = 23,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      ready,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      overflow,
    output logic                      div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      fin;     // all iterations done, results pending
    logic [DIVIDEND_WIDTH-1:0] sh;      // dividend shifts out, quotient shifts in
    logic [DIVISOR_WIDTH-1:0]  dsr;
    logic [DIVISOR_WIDTH:0]    prem;    // partial remainder

    logic [DIVISOR_WIDTH:0]    shifted;
    logic [DIVISOR_WIDTH+1:0]  diff;
    logic                      ge;

    // prem < dsr always holds, so prem's MSB is zero and the shift cannot lose
    // information; one extra bit on diff gives the borrow.
    assign shifted = {prem[DIVISOR_WIDTH-1:0], sh[DIVIDEND_WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dsr};
    assign ge      = ~diff[DIVISOR_WIDTH+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            fin         <= 1'b0;
            sh          <= '0;
            dsr         <= '0;
            prem        <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= dividend;
                        dsr   <= divisor;
                        prem  <= '0;
                        cnt   <= CW'(DIVIDEND_WIDTH - 1);
                        fin   <= 1'b0;
                        ready <= 1'b0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (fin) begin
                        // Divide by zero runs the same iterations for fixed
                        // latency; its raw result is discarded here.
                        if (dsr == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            if (sh[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH] != '0) begin
                                quotient <= '1;
                                overflow <= 1'b1;
                            end else begin
                                quotient <= sh[QUOTIENT_WIDTH-1:0];
                                overflow <= 1'b0;
                            end
                            remainder   <= prem[DIVISOR_WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                        fin   <= 1'b0;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        prem <= ge ? diff[DIVISOR_WIDTH:0] : shifted;
                        sh   <= {sh[DIVIDEND_WIDTH-2:0], ge};
                        if (cnt == '0) fin <= 1'b1;
                        else           cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_face_detect_udiv_23ns_8ns_16_seq.sv
module tb_face_detect_udiv_23ns_8ns_16_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [22:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        ready, done, overflow, div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int checks = 0;
    int errors = 0;

    face_detect_udiv_23ns_8ns_16_seq dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request, let one edge accept it, then scramble the inputs.
    task automatic accept(input logic [22:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 23'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Count edges until done is seen; ready must stay low until then.
    task automatic wait_done(output int n, output bit rdy_bad);
        n = 0;
        rdy_bad = 1'b0;
        while (!done && n < 100) begin
            if (ready) rdy_bad = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        int  n, n2;
        bit  rb;
        bit  seen;
        logic [15:0] prev_q;

        vt[0]  = '{23'd1000,     8'd7,   16'd142,    8'd6,   1'b0, 1'b0};
        vt[1]  = '{23'h7FFFFF,   8'd255, 16'h8080,   8'd127, 1'b0, 1'b0};
        vt[2]  = '{23'h10000,    8'd1,   16'hFFFF,   8'd0,   1'b1, 1'b0};
        vt[3]  = '{23'hFFFF,     8'd1,   16'hFFFF,   8'd0,   1'b0, 1'b0};
        vt[4]  = '{23'd12345,    8'd0,   16'hFFFF,   8'd0,   1'b0, 1'b1};
        vt[5]  = '{23'd10,       8'd3,   16'd3,      8'd1,   1'b0, 1'b0};
        vt[6]  = '{23'd0,        8'd5,   16'd0,      8'd0,   1'b0, 1'b0};
        vt[7]  = '{23'd254,      8'd255, 16'd0,      8'd254, 1'b0, 1'b0};
        vt[8]  = '{23'h7FFFFF,   8'd128, 16'hFFFF,   8'd127, 1'b0, 1'b0};
        vt[9]  = '{23'h7FFFFF,   8'd127, 16'hFFFF,   8'd3,   1'b1, 1'b0};
        vt[10] = '{23'h123456,   8'd128, 16'd9320,   8'd86,  1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors
        prev_q = 16'd0;
        foreach (vt[i]) begin
            accept(vt[i].a, vt[i].b);
            chk($sformatf("v%0d_hold_q", i), quotient, prev_q);
            chk($sformatf("v%0d_done_lo", i), done, 0);
            wait_done(n, rb);
            chk($sformatf("v%0d_lat", i), n, 24);
            chk($sformatf("v%0d_rdy_low", i), rb, 0);
            chk($sformatf("v%0d_ready", i), ready, 1);
            chk($sformatf("v%0d_q", i), quotient, vt[i].q);
            chk($sformatf("v%0d_r", i), remainder, vt[i].r);
            chk($sformatf("v%0d_ovf", i), overflow, vt[i].ovf);
            chk($sformatf("v%0d_dbz", i), div_by_zero, vt[i].dbz);
            tick();
            chk($sformatf("v%0d_pulse", i), done, 0);
            prev_q = vt[i].q;
        end

        // Start during CALC is ignored
        accept(23'd1000, 8'd7);
        repeat (5) tick();
        dividend = 23'd10;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(n, rb);
        chk("busy_start_lat", n + 6, 24);
        chk("busy_start_q", quotient, 142);
        chk("busy_start_r", remainder, 6);
        tick();

        // ce stall mid-CALC, then ce low while in DONE
        accept(23'd1000, 8'd7);
        repeat (10) tick();
        ce = 1'b0;
        repeat (5) tick();
        ce = 1'b1;
        wait_done(n, rb);
        chk("stall_lat", n + 15, 29);
        chk("stall_q", quotient, 142);
        chk("stall_r", remainder, 6);
        ce = 1'b0;
        repeat (3) tick();
        chk("stall_done_hold", done, 1);
        ce = 1'b1;
        tick();
        chk("stall_done_drop", done, 0);

        // Back-to-back: start on the DONE edge
        accept(23'd1000, 8'd7);
        wait_done(n, rb);
        chk("b2b_first_lat", n, 24);
        dividend = 23'd10;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("b2b_done_lo", done, 0);
        chk("b2b_ready_lo", ready, 0);
        chk("b2b_hold_q", quotient, 142);
        wait_done(n2, rb);
        chk("b2b_second_lat", n2, 24);
        chk("b2b_q", quotient, 3);
        chk("b2b_r", remainder, 1);
        tick();

        // Reset mid-CALC abandons the operation
        accept(23'h7FFFFF, 8'd255);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("mid_rst_no_done", seen, 0);
        chk("mid_rst_idle_ready", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
